// File: rtl/kp_pkg.sv
// Shared keypad-scanner definitions: FSM encoding, default timing, key-code width.
package kp_pkg;

  localparam int SCAN_DIV_DEF = 1000;
  localparam int DEBOUNCE_DEF = 20000;
  localparam int KEY_W        = 4;

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    HELD      = 2'd2,
    DEB_REL   = 2'd3
  } state_t;

  // Lowest-index active-low row wins when several rows are pulled down.
  function automatic logic [1:0] low_idx(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

endpackage

// File: rtl/kp_if.sv
// Keypad lines plus the key-code valid/ack handshake toward the consumer.
interface kp_if;
  import kp_pkg::*;

  logic [3:0]       row;
  logic [3:0]       col;
  logic [KEY_W-1:0] key;
  logic             key_valid;
  logic             key_ack;
  logic             pressed;
  logic             overrun;

  modport master (
    input  row, key_ack,
    output col, key, key_valid, pressed, overrun
  );

  modport slave (
    output row, key_ack,
    input  col, key, key_valid, pressed, overrun
  );

endinterface

// File: rtl/kp_sync.sv
// Two-flop synchronizer for the 4 asynchronous row lines; resets to idle (all high).
module kp_sync (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] s1;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= 4'hF;
      q  <= 4'hF;
    end else begin
      s1 <= d;
      q  <= s1;
    end
  end

endmodule

// File: rtl/kp_scanner.sv
// 4x4 keypad scanner: column strobe, debounced press/release, one key code per press.
// key_valid rises DEBOUNCE clocks after press detection; a press accepted while unacked sets overrun.
module kp_scanner
  import kp_pkg::*;
#(
  parameter int SCAN_DIV = SCAN_DIV_DEF,
  parameter int DEBOUNCE = DEBOUNCE_DEF
) (
  input logic clk,
  input logic reset,
  kp_if.master kp
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEBOUNCE);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE - 1);

  logic [3:0]       rs;
  state_t           state, state_nxt;
  logic [DIV_W-1:0] div, div_nxt;
  logic [DEB_W-1:0] cnt, cnt_nxt;
  logic [1:0]       col_idx, col_nxt;
  logic [1:0]       row_idx, row_nxt;
  logic [KEY_W-1:0] key, key_nxt;
  logic             kv, kv_nxt;
  logic             ovr, ovr_nxt;
  logic             accept;

  kp_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (kp.row),
    .q     (rs)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= SCAN;
      div     <= '0;
      cnt     <= '0;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      key     <= '0;
      kv      <= 1'b0;
      ovr     <= 1'b0;
    end else begin
      state   <= state_nxt;
      div     <= div_nxt;
      cnt     <= cnt_nxt;
      col_idx <= col_nxt;
      row_idx <= row_nxt;
      key     <= key_nxt;
      kv      <= kv_nxt;
      ovr     <= ovr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    div_nxt   = div;
    cnt_nxt   = cnt;
    col_nxt   = col_idx;
    row_nxt   = row_idx;
    accept    = 1'b0;
    case (state)
      SCAN: begin
        if (div == DIV_LAST) begin
          div_nxt = '0;
          if (rs != 4'hF) begin
            row_nxt   = low_idx(rs);
            cnt_nxt   = '0;
            state_nxt = DEB_PRESS;
          end else begin
            col_nxt = col_idx + 2'd1;
          end
        end else begin
          div_nxt = div + 1'b1;
        end
      end
      DEB_PRESS: begin
        if (rs[row_idx]) begin
          state_nxt = SCAN;
          cnt_nxt   = '0;
          div_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          accept    = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HELD: begin
        if (rs[row_idx]) begin
          state_nxt = DEB_REL;
          cnt_nxt   = '0;
        end
      end
      DEB_REL: begin
        if (!rs[row_idx]) begin
          state_nxt = HELD;
        end else if (cnt == DEB_LAST) begin
          state_nxt = SCAN;
          col_nxt   = col_idx + 2'd1;
          div_nxt   = '0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = SCAN;
    endcase
  end

  // An ack in the acceptance cycle frees the slot, so the new code replaces the old one.
  always_comb begin
    key_nxt = key;
    kv_nxt  = kv;
    ovr_nxt = ovr;
    if (accept && (!kv || kp.key_ack)) begin
      key_nxt = {col_idx, row_idx};
      kv_nxt  = 1'b1;
      if (kv) ovr_nxt = 1'b0;
    end else begin
      if (accept) ovr_nxt = 1'b1;
      if (kv && kp.key_ack) begin
        kv_nxt  = 1'b0;
        ovr_nxt = 1'b0;
      end
    end
  end

  assign kp.col       = ~(4'b0001 << col_idx);
  assign kp.key       = key;
  assign kp.key_valid = kv;
  assign kp.overrun   = ovr;
  assign kp.pressed   = (state != SCAN);

endmodule

// File: tb/tb_kp_scanner.sv
// Bench for kp_scanner with SCAN_DIV=4, DEBOUNCE=8: keypad matrix emulation, per-cycle model compare, directed checks.
module tb_kp_scanner;

  localparam int SD = 4;
  localparam int DB = 8;

  localparam int P_SCAN = 0;
  localparam int P_PRESS = 1;
  localparam int P_HELD = 2;
  localparam int P_REL = 3;

  logic clk;
  logic reset;
  logic chk_en;
  logic [15:0] keys_down;
  logic [3:0] row_w;
  logic [3:0] one4;
  int total;
  int bad;
  int n;

  kp_if kpi ();

  kp_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
    .clk   (clk),
    .reset (reset),
    .kp    (kpi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a held key pulls its row low only while its column is strobed.
  always_comb begin
    row_w = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys_down[c*4+r] && !kpi.col[c]) row_w[r] = 1'b0;
  end
  assign kpi.row = row_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // sel: 0 key_valid, 1 pressed, 2 overrun. n = clocks until the level is seen.
  task automatic wait_lvl(input int sel, input logic lvl, input int lim, input string nm, output int cyc);
    logic v;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      case (sel)
        0: v = kpi.key_valid;
        1: v = kpi.pressed;
        default: v = kpi.overrun;
      endcase
    end while (v !== lvl && cyc < lim);
    if (v !== lvl) begin
      total++;
      bad++;
      $display("FAIL %s: level %b after %0d cycles, required %b", nm, v, cyc, lvl);
    end
  endtask

  // Behavioural model: dwell/stable-sample counting directly from the timing rules.
  int m_phase, m_col, m_dwell, m_stable, m_row, m_key;
  logic m_kv, m_ovr, acc, ackd;
  logic [3:0] m_s1, m_rs, old_rs;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = P_SCAN; m_col = 0; m_dwell = 0; m_stable = 0; m_row = 0;
      m_key = 0; m_kv = 1'b0; m_ovr = 1'b0; m_s1 = 4'hF; m_rs = 4'hF;
    end else begin
      old_rs = m_rs;
      m_rs = m_s1;
      m_s1 = kpi.row;
      acc = 1'b0;
      ackd = m_kv && kpi.key_ack;
      case (m_phase)
        P_SCAN: begin
          m_dwell++;
          if (m_dwell == SD) begin
            m_dwell = 0;
            if (old_rs != 4'hF) begin
              for (int r = 3; r >= 0; r--) if (!old_rs[r]) m_row = r;
              m_phase = P_PRESS;
              m_stable = 0;
            end else m_col = (m_col + 1) % 4;
          end
        end
        P_PRESS: begin
          if (old_rs[m_row]) begin
            m_phase = P_SCAN;
            m_dwell = 0;
          end else begin
            m_stable++;
            if (m_stable == DB) begin
              m_phase = P_HELD;
              acc = 1'b1;
            end
          end
        end
        P_HELD: begin
          if (old_rs[m_row]) begin
            m_phase = P_REL;
            m_stable = 0;
          end
        end
        default: begin
          if (!old_rs[m_row]) m_phase = P_HELD;
          else begin
            m_stable++;
            if (m_stable == DB) begin
              m_phase = P_SCAN;
              m_col = (m_col + 1) % 4;
              m_dwell = 0;
            end
          end
        end
      endcase
      if (acc && (!m_kv || kpi.key_ack)) begin
        m_key = m_col * 4 + m_row;
        m_kv = 1'b1;
        if (ackd) m_ovr = 1'b0;
      end else begin
        if (acc) m_ovr = 1'b1;
        if (ackd) begin
          m_kv = 1'b0;
          m_ovr = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("col", 32'(kpi.col), 32'(4'hF ^ (one4 << m_col)));
      chk("key", 32'(kpi.key), 32'(m_key));
      chk("key_valid", 32'(kpi.key_valid), 32'(m_kv));
      chk("overrun", 32'(kpi.overrun), 32'(m_ovr));
      chk("pressed", 32'(kpi.pressed), 32'(m_phase != P_SCAN));
    end
  end

  initial begin
    total = 0;
    bad = 0;
    one4 = 4'b0001;
    chk_en = 1'b0;
    reset = 1'b1;
    keys_down = 16'h0;
    kpi.key_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_col", 32'(kpi.col), 32'h0000_000E);
    chk("rst_kv", 32'(kpi.key_valid), 32'h0);
    reset = 1'b0;

    // Idle scan: four clocks per column.
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      chk("scan_col", 32'(kpi.col), 32'(4'hF ^ (one4 << ((k / 4) % 4))));
    end
    chk("scan_kv", 32'(kpi.key_valid), 32'h0);

    // Key 0xA (column 2, row 2): press, ack, long hold, release.
    keys_down[10] = 1'b1;
    wait_lvl(1, 1'b1, 100, "a_press", n);
    wait_lvl(0, 1'b1, 100, "a_valid", n);
    chk("a_latency", 32'(n), 32'd8);
    chk("a_key", 32'(kpi.key), 32'hA);
    kpi.key_ack = 1'b1;
    @(negedge clk);
    kpi.key_ack = 1'b0;
    chk("a_ack_kv", 32'(kpi.key_valid), 32'h0);
    repeat (30) @(negedge clk);
    chk("a_held", 32'(kpi.pressed), 32'h1);
    keys_down = 16'h0;
    wait_lvl(1, 1'b0, 100, "a_release", n);
    chk("a_rel_latency", 32'(n), 32'd11);
    chk("a_rel_col", 32'(kpi.col), 32'h7);
    repeat (40) @(negedge clk);
    chk("a_no_repeat", 32'(kpi.key_valid), 32'h0);

    // Bounce on key 0x5: too short to be accepted.
    keys_down[5] = 1'b1;
    wait_lvl(1, 1'b1, 100, "b_press", n);
    repeat (3) @(negedge clk);
    keys_down = 16'h0;
    wait_lvl(1, 1'b0, 100, "b_abort", n);
    chk("b_abort_lat", 32'(n), 32'd3);
    repeat (4) @(negedge clk);
    chk("b_resume_col", 32'(kpi.col), 32'hB);
    chk("b_kv", 32'(kpi.key_valid), 32'h0);

    // Two keys without ack: first code kept, overrun set, ack clears both.
    keys_down[0] = 1'b1;
    wait_lvl(0, 1'b1, 200, "c_valid0", n);
    chk("c_key0", 32'(kpi.key), 32'h0);
    keys_down = 16'h0;
    wait_lvl(1, 1'b0, 100, "c_rel0", n);
    keys_down[5] = 1'b1;
    wait_lvl(2, 1'b1, 200, "c_overrun", n);
    chk("c_key_kept", 32'(kpi.key), 32'h0);
    chk("c_kv", 32'(kpi.key_valid), 32'h1);
    keys_down = 16'h0;
    wait_lvl(1, 1'b0, 100, "c_rel5", n);
    kpi.key_ack = 1'b1;
    @(negedge clk);
    kpi.key_ack = 1'b0;
    chk("c_ack_kv", 32'(kpi.key_valid), 32'h0);
    chk("c_ack_ovr", 32'(kpi.overrun), 32'h0);

    // Rows 0 and 3 together on column 0, then 0xF accepted in the ack cycle.
    keys_down = 16'h0009;
    wait_lvl(0, 1'b1, 200, "d_valid", n);
    chk("d_key_prio", 32'(kpi.key), 32'h0);
    keys_down = 16'h0;
    wait_lvl(1, 1'b0, 100, "d_rel", n);
    keys_down[15] = 1'b1;
    wait_lvl(1, 1'b1, 200, "d_pressF", n);
    repeat (7) @(negedge clk);
    kpi.key_ack = 1'b1;
    @(negedge clk);
    kpi.key_ack = 1'b0;
    chk("d_reload_kv", 32'(kpi.key_valid), 32'h1);
    chk("d_reload_key", 32'(kpi.key), 32'hF);
    chk("d_reload_ovr", 32'(kpi.overrun), 32'h0);

    // Reset while 0xF is held: outputs clear, key re-reported after full debounce.
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("r_col", 32'(kpi.col), 32'hE);
    chk("r_key", 32'(kpi.key), 32'h0);
    chk("r_kv", 32'(kpi.key_valid), 32'h0);
    chk("r_pressed", 32'(kpi.pressed), 32'h0);
    chk("r_ovr", 32'(kpi.overrun), 32'h0);
    reset = 1'b0;
    wait_lvl(1, 1'b1, 200, "r_press", n);
    wait_lvl(0, 1'b1, 100, "r_valid", n);
    chk("r_latency", 32'(n), 32'd8);
    chk("r_key_again", 32'(kpi.key), 32'hF);
    keys_down = 16'h0;
    kpi.key_ack = 1'b1;
    @(negedge clk);
    kpi.key_ack = 1'b0;
    wait_lvl(1, 1'b0, 100, "r_rel", n);
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kp_scanner.md
KP_SCANNER -- requirements
Module: kp_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 1000: clocks each column is driven before the scan advances; legal range 2..65535.
REQ-002 Parameter DEBOUNCE, default 20000: consecutive stable clocks required to accept a press or a release; legal range 2..2^20-1.
REQ-003 clk  input  1  system clock; every flop is on its rising edge.
REQ-004 reset  input  1  synchronous reset, active-high; it is sampled only on a rising clk edge.
REQ-005 row  input  4  keypad row lines, active-low, externally pulled up, asynchronous to clk.
REQ-006 col  output  4  keypad column strobes, one-hot active-low (exactly one bit is 0).
REQ-007 key  output  4  accepted key code, calculated as col_idx*4 + row_idx.
REQ-008 key_valid  output  1  high while an accepted key code is waiting for the consumer.
REQ-009 key_ack  input  1  consumer acknowledge; it is sampled only while key_valid=1.
REQ-010 pressed  output  1  level output, high in states DEB_PRESS, HELD and DEB_REL.
REQ-011 overrun  output  1  sticky flag: a key was accepted while key_valid was already 1.

Function
REQ-012 row SHALL pass through a 2-flop synchronizer; all further logic SHALL use only the synchronized value rs.
REQ-013 States SHALL be SCAN, DEB_PRESS, HELD and DEB_REL.
REQ-014 SCAN:
- col_idx SHALL advance 0->1->2->3->0 every SCAN_DIV clocks.
- col SHALL equal ~(1<<col_idx).
REQ-015 SCAN exit: on the last dwell clock of a column, if any rs bit is 0:
- row_idx SHALL capture the lowest-index 0 bit (priority to row 0);
- col_idx SHALL freeze;
- the FSM SHALL go to DEB_PRESS with the stable counter cleared.
REQ-016 DEB_PRESS:
- counter SHALL increment each clock while rs[row_idx]=0;
- if rs[row_idx]=1, the FSM SHALL return to SCAN, clear the counter, and advance col_idx on the next dwell boundary;
- when the counter reaches DEBOUNCE-1, the FSM SHALL enter HELD.
REQ-017 Press latency: key_valid SHALL assert exactly DEBOUNCE clocks after entry to DEB_PRESS, provided the row stays low throughout.
REQ-018 On entry to HELD:
- if key_valid=0, or key_ack=1 in the same cycle: key<=code and key_valid<=1;
- otherwise: key SHALL hold its old value and overrun<=1.
REQ-019 HELD: col SHALL stay frozen; rs[row_idx]=1 SHALL move the FSM to DEB_REL with the counter cleared.
REQ-020 DEB_REL:
- counter SHALL increment each clock while rs[row_idx]=1;
- rs[row_idx]=0 SHALL return the FSM to HELD and SHALL NOT produce a new key_valid;
- reaching DEBOUNCE-1 SHALL move the FSM to SCAN, with col_idx advanced by one.
REQ-021 key_valid=1 with key_ack=1 SHALL clear key_valid and overrun on the next edge, unless REQ-018 reloads in that same cycle.
REQ-022 key_ack while key_valid=0 SHALL be ignored.
REQ-023 A key held indefinitely SHALL generate exactly one key_valid; there is no auto-repeat.
REQ-024 key SHALL hold stable for the whole time key_valid=1.
REQ-025 Counter widths SHALL be ceil(log2(param)) bits; wrap-around SHALL be unreachable by construction.

Reset
REQ-026 On reset=1 at a clock edge, the following values SHALL apply on the next cycle regardless of state:
- state=SCAN, col_idx=0, col=4'b1110;
- key=0, key_valid=0, pressed=0, overrun=0;
- counters=0, synchronizer flops=4'b1111.
REQ-027 A key that is still held when reset releases SHALL be re-detected through the full DEB_PRESS sequence.

Structure
REQ-028 Package kp_pkg SHALL hold the state encoding, the default SCAN_DIV/DEBOUNCE values and the key-code width constant.
REQ-029 The synchronizer SHALL be the sub-module kp_sync (4-bit, 2-flop, reset to all 1s).
REQ-030 The FSM, counters and output handshake SHALL stay in kp_scanner.

Verification (SCAN_DIV=4, DEBOUNCE=8)
REQ-031 Reset, then no press -> col cycles 1110, 1101, 1011, 0111, 1110 at 4 clocks each; key_valid stays 0.
REQ-032 row[2] low when col=1011, held 40 clocks, then released; key_ack pulsed once -> key=0xA, key_valid rises 8 clocks after DEB_PRESS entry, pressed falls after 8 stable-high clocks, no second key_valid.
REQ-033 Bounce: row[1] low for 5 clocks, then high -> return to SCAN, key_valid stays 0, scan resumes.
REQ-034 Two keys (0x0, then 0x5) with no key_ack -> key stays 0x0, overrun=1; one key_ack -> key_valid=0, overrun=0.
REQ-035 row[0] and row[3] low together on col 0 -> key=0x0; new key accepted in the same cycle as key_ack -> key_valid stays 1 with the new code.
REQ-036 reset asserted during HELD with the key still held -> all outputs return to reset values; key re-reported after 8 debounce clocks.
